item_memory_mport_top: RTL and testbench

ITEM_MEMORY_MPORT_TOP -- requirements
Module: item_memory_mport_top

---
 rtl/item_memory_mport_top.sv | 112 +++++++++++
 tb/tb_item_memory_mport_top.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/item_memory_mport_top.sv
// Multi-port item-memory fetch stage: each port looks up (or bypasses) a
// hypervector, optionally rotates it, and buffers it in a small hold FIFO
// ahead of the encoder. A shared counter records cycles lost to pops on
// empty ports.
module item_memory_mport_top #(
   parameter  int unsigned HVDimension   = 512,
   parameter  int unsigned NumPorts      = 4,
   parameter  int unsigned ImAddrWidth   = 32,
   parameter  int unsigned FifoDepth     = 2,
   parameter  int unsigned StallCntWidth = 32,
   localparam int unsigned PermWidth     = $clog2(HVDimension),
   localparam int unsigned PtrWidth      = $clog2(FifoDepth),
   localparam int unsigned OccWidth      = $clog2(FifoDepth) + 1
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NumPorts-1:0][1:0]               port_mode_i,
   input  logic [NumPorts-1:0][PermWidth-1:0]     perm_amt_i,
   input  logic                                   clr_i,
   input  logic                                   enable_i,
   input  logic [NumPorts-1:0][ImAddrWidth-1:0]   lowdim_data_i,
   input  logic [NumPorts-1:0][HVDimension-1:0]   highdim_data_i,
   input  logic [NumPorts-1:0]                    data_valid_i,
   output logic [NumPorts-1:0]                    data_ready_o,
   output logic [NumPorts-1:0][ImAddrWidth-1:0]   im_addr_o,
   input  logic [NumPorts-1:0][HVDimension-1:0]   im_hv_i,
   output logic [NumPorts-1:0][HVDimension-1:0]   im_o,
   input  logic [NumPorts-1:0]                    im_pop_i,
   output logic [NumPorts-1:0][OccWidth-1:0]      occupancy_o,
   output logic                                   stall_o,
   output logic [StallCntWidth-1:0]               stall_cnt_o
);

   logic [NumPorts-1:0]      empty;
   logic [StallCntWidth-1:0] stall_cnt;

   for (genvar p = 0; p < NumPorts; p++) begin : g_port
      logic [HVDimension-1:0] mem [FifoDepth];
      logic [PtrWidth-1:0]    rd_ptr;
      logic [PtrWidth-1:0]    wr_ptr;
      logic [OccWidth-1:0]    occ;
      logic [HVDimension-1:0] push_data;
      logic                   full;
      logic                   ready;
      logic                   push;
      logic                   pop;

      // Choose the pushed vector: lookup, bypass, or rotated lookup
      always_comb begin
         push_data = im_hv_i[p];
         case (port_mode_i[p])
            2'd1:    push_data = highdim_data_i[p];
            // upper half of the doubled word shifted left is the left rotation
            2'd2:    push_data = HVDimension'(({im_hv_i[p], im_hv_i[p]} << perm_amt_i[p]) >> HVDimension);
            default: push_data = im_hv_i[p];
         endcase
      end

      assign full     = (occ == OccWidth'(FifoDepth));
      assign empty[p] = (occ == '0);
      assign ready    = enable_i && !full && !clr_i;
      assign push     = data_valid_i[p] && ready;
      assign pop      = im_pop_i[p] && !empty[p];

      assign data_ready_o[p] = ready;
      assign im_addr_o[p]    = lowdim_data_i[p];
      assign occupancy_o[p]  = occ;
      assign im_o[p]         = empty[p] ? '0 : mem[rd_ptr];

      // Hold FIFO: wrap-around pointers, occupancy tracks push/pop balance
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            mem    <= '{default: '0};
         end else if (clr_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= push_data;
               wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
               occ <= occ + 1'b1;
            end else if (!push && pop) begin
               occ <= occ - 1'b1;
            end
         end
      end
   end

   assign stall_o     = |(im_pop_i & empty);
   assign stall_cnt_o = stall_cnt;

   // Count cycles where any port is asked for data it does not have
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt <= '0;
      end else if (clr_i) begin
         stall_cnt <= '0;
      end else if (stall_o && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_item_memory_mport_top.sv
// Bench for item_memory_mport_top: directed scenarios with literal
// expectations plus randomized traffic against a list-based port model.
module tb_item_memory_mport_top;
   localparam int unsigned D  = 16;
   localparam int unsigned NP = 2;
   localparam int unsigned AW = 16;
   localparam int unsigned FD = 2;
   localparam int unsigned PW = 4;
   localparam int unsigned OW = 2;
   localparam int unsigned SW = 8;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NP-1:0][1:0]     port_mode;
   logic [NP-1:0][PW-1:0]  perm_amt;
   logic                   clr;
   logic                   enable;
   logic [NP-1:0][AW-1:0]  lowdim;
   logic [NP-1:0][D-1:0]   highdim;
   logic [NP-1:0]          valid;
   logic [NP-1:0]          ready;
   logic [NP-1:0][AW-1:0]  im_addr;
   logic [NP-1:0][D-1:0]   im_hv;
   logic [NP-1:0][D-1:0]   im_out;
   logic [NP-1:0]          pop;
   logic [NP-1:0][OW-1:0]  occ;
   logic                   stall;
   logic [SW-1:0]          stall_cnt;

   int errors = 0;
   int checks = 0;

   // model: per-port ordered list of held entries and the stall counter
   logic [D-1:0] mq [NP][FD];
   int           mn [NP];
   int unsigned  m_cnt;

   always #5 clk = ~clk;

   item_memory_mport_top #(
      .HVDimension  (D),
      .NumPorts     (NP),
      .ImAddrWidth  (AW),
      .FifoDepth    (FD),
      .StallCntWidth(SW)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .port_mode_i   (port_mode),
      .perm_amt_i    (perm_amt),
      .clr_i         (clr),
      .enable_i      (enable),
      .lowdim_data_i (lowdim),
      .highdim_data_i(highdim),
      .data_valid_i  (valid),
      .data_ready_o  (ready),
      .im_addr_o     (im_addr),
      .im_hv_i       (im_hv),
      .im_o          (im_out),
      .im_pop_i      (pop),
      .occupancy_o   (occ),
      .stall_o       (stall),
      .stall_cnt_o   (stall_cnt)
   );

   // external combinational item memory: byte swap, port-specific xor
   function automatic logic [D-1:0] imem(logic [AW-1:0] a, int p);
      return {a[7:0], a[15:8]} ^ ((p == 1) ? 16'h1111 : 16'h0000);
   endfunction

   always_comb begin
      for (int p = 0; p < NP; p++) im_hv[p] = imem(im_addr[p], p);
   end

   function automatic logic [D-1:0] rotl(logic [D-1:0] v, int k);
      logic [D-1:0] r;
      r = '0;
      for (int i = 0; i < D; i++) r[(i + k) % D] = v[i];
      return r;
   endfunction

   function automatic logic [D-1:0] model_sel(int p);
      logic [D-1:0] hv;
      hv = imem(lowdim[p], p);
      case (port_mode[p])
         2'd1:    return highdim[p];
         2'd2:    return rotl(hv, int'(perm_amt[p]));
         default: return hv;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         mn[p] = 0;
         for (int e = 0; e < FD; e++) mq[p][e] = '0;
      end
      m_cnt = 0;
   endtask

   task automatic compare();
      bit st;
      st = 1'b0;
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("im_addr[%0d]", p), im_addr[p], lowdim[p]);
         chk($sformatf("ready[%0d]", p), ready[p], enable && (mn[p] < FD) && !clr);
         chk($sformatf("occupancy[%0d]", p), occ[p], mn[p]);
         chk($sformatf("im_o[%0d]", p), im_out[p], (mn[p] > 0) ? mq[p][0] : 16'h0);
         if (pop[p] && mn[p] == 0) st = 1'b1;
      end
      chk("stall_o", stall, st);
      chk("stall_cnt", stall_cnt, m_cnt);
   endtask

   task automatic advance();
      bit st;
      bit rdy, psh, pp;
      if (!rst_n || clr) begin
         model_reset();
         return;
      end
      st = 1'b0;
      for (int p = 0; p < NP; p++) if (pop[p] && mn[p] == 0) st = 1'b1;
      for (int p = 0; p < NP; p++) begin
         rdy = enable && (mn[p] < FD);
         psh = valid[p] && rdy;
         pp  = pop[p] && (mn[p] > 0);
         if (pp) begin
            for (int e = 0; e < FD - 1; e++) mq[p][e] = mq[p][e + 1];
            mn[p]--;
         end
         if (psh) begin
            mq[p][mn[p]] = model_sel(p);
            mn[p]++;
         end
      end
      if (st && m_cnt != 255) m_cnt++;
   endtask

   // inputs settle, compare against model, model takes the edge, next negedge
   task automatic step();
      #1;
      compare();
      advance();
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      enable    = 1'b0;
      port_mode = '0;
      perm_amt  = '0;
      lowdim    = '0;
      highdim   = '0;
      valid     = '0;
      pop       = '0;
      model_reset();

      @(negedge clk);
      chk("reset occupancy", occ, 0);
      chk("reset im_o", im_out, 0);
      chk("reset stall_cnt", stall_cnt, 0);
      chk("reset ready en0", ready, 0);
      enable = 1'b1;
      #1;
      chk("reset ready en1", ready, 2'b11);
      enable = 1'b0;
      step();
      rst_n = 1'b1;
      enable = 1'b1;
      step();

      // bypass mode fill then drain in order
      port_mode[0] = 2'd1;
      valid[0] = 1'b1; highdim[0] = 16'h00A5; step();
      highdim[0] = 16'h1234; step();
      valid[0] = 1'b0;
      #1;
      chk("fill occ0", occ[0], 2);
      chk("fill ready0", ready[0], 0);
      chk("fill head0", im_out[0], 16'h00A5);
      pop[0] = 1'b1; step();
      chk("drain head0 a", im_out[0], 16'h1234);
      step();
      chk("drain head0 b", im_out[0], 16'h0000);
      chk("drain occ0", occ[0], 0);
      pop[0] = 1'b0;

      // rotated lookup on port 1
      port_mode[1] = 2'd2;
      perm_amt[1] = 4'd3; lowdim[1] = 16'h1011; valid[1] = 1'b1; step();
      valid[1] = 1'b0;
      #1;
      chk("rot3", im_out[1], 16'h0008);
      perm_amt[1] = 4'd15; lowdim[1] = 16'h1091; valid[1] = 1'b1; step();
      valid[1] = 1'b0; pop[1] = 1'b1; step();
      pop[1] = 1'b0;
      #1;
      chk("rot15", im_out[1], 16'hC000);
      pop[1] = 1'b1; step();
      pop[1] = 1'b0;

      // stall on both empty ports
      clr = 1'b1; step(); clr = 1'b0;
      pop = 2'b11;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall high", stall, 1);
         step();
      end
      pop = 2'b00;
      #1;
      chk("stall count 3", stall_cnt, 3);
      chk("stall occ", occ, 0);

      // full port: valid with pop, then push accepted
      port_mode[0] = 2'd1;
      valid[0] = 1'b1; highdim[0] = 16'h0011; step();
      highdim[0] = 16'h0022; step();
      highdim[0] = 16'h0033; pop[0] = 1'b1;
      #1;
      chk("full ready0", ready[0], 0);
      chk("full ready1 indep", ready[1], 1);
      step();
      chk("full pop occ", occ[0], 1);
      chk("full pop head", im_out[0], 16'h0022);
      pop[0] = 1'b0; step();
      chk("refill occ", occ[0], 2);
      valid[0] = 1'b0;

      // soft clear with occupancy {2,1} and five stalls
      port_mode[1] = 2'd1;
      pop[1] = 1'b1; step(); step();
      pop[1] = 1'b0; valid[1] = 1'b1; highdim[1] = 16'h0077; step();
      valid[1] = 1'b0;
      #1;
      chk("pre-clr occ0", occ[0], 2);
      chk("pre-clr occ1", occ[1], 1);
      chk("pre-clr stall_cnt", stall_cnt, 5);
      clr = 1'b1; step(); clr = 1'b0;
      #1;
      chk("clr occ", occ, 0);
      chk("clr stall_cnt", stall_cnt, 0);
      chk("clr im_o", im_out, 0);

      // disabled: no push, pops still drain
      valid[0] = 1'b1; highdim[0] = 16'h00AA; step();
      highdim[0] = 16'h00BB; step();
      enable = 1'b0; pop[0] = 1'b1;
      #1;
      chk("dis ready0", ready[0], 0);
      step();
      chk("dis occ a", occ[0], 1);
      chk("dis head", im_out[0], 16'h00BB);
      step();
      chk("dis occ b", occ[0], 0);
      pop[0] = 1'b0; valid[0] = 1'b0; enable = 1'b1;

      // stall counter saturation
      clr = 1'b1; step(); clr = 1'b0;
      pop = 2'b11;
      for (int i = 0; i < 260; i++) step();
      pop = 2'b00;
      #1;
      chk("stall saturate", stall_cnt, 255);

      // reset mid-transfer loses buffered entries
      valid[1] = 1'b1; highdim[1] = 16'h1357; step();
      highdim[1] = 16'h2468; step();
      valid[1] = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid-reset occ1", occ[1], 0);
      chk("mid-reset im_o1", im_out[1], 0);
      step();
      rst_n = 1'b1; step();
      valid[1] = 1'b1; highdim[1] = 16'hBEEF; step();
      valid[1] = 1'b0;
      #1;
      chk("post-reset head", im_out[1], 16'hBEEF);
      pop[1] = 1'b1; step();
      pop[1] = 1'b0;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         enable = ($urandom_range(9) != 0);
         clr    = ($urandom_range(49) == 0);
         for (int p = 0; p < NP; p++) begin
            port_mode[p] = 2'($urandom_range(3));
            perm_amt[p]  = PW'($urandom_range(15));
            lowdim[p]    = AW'($urandom);
            highdim[p]   = D'($urandom);
            valid[p]     = 1'($urandom_range(1));
            pop[p]       = ($urandom_range(2) != 0);
         end
         if ($urandom_range(299) == 0) begin
            rst_n = 1'b0;
            model_reset();
            step();
            rst_n = 1'b1;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
